// File: rtl/dpram_pkg.sv
// Shared types and constants for the parameterised dual-port RAM.
// Imported by the interface, the clear controller and the top.
package dpram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;
  localparam int PRIO_A      = 0;
  localparam int PRIO_B      = 1;

  function automatic int calc_nb(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dual_port_ram_param_if.sv
// One RAM port's access bundle; the top takes one instance per port.
interface dual_port_ram_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  import dpram_pkg::*;

  localparam int NB = calc_nb(DATA_WIDTH, BYTE_WIDTH);

  logic                  en;
  logic                  write_enable;
  logic [NB-1:0]         byte_enable;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;

  modport master (
    output en, write_enable, byte_enable, address, data_in,
    input  data_out, valid
  );

  modport slave (
    input  en, write_enable, byte_enable, address, data_in,
    output data_out, valid
  );

endinterface

// File: rtl/dpram_clear_ctrl.sv
// CLEAR/RUN sequencer: after reset it sweeps the array two words per edge,
// then releases the RAM to the user ports.
module dpram_clear_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_addr_even,
  output logic [ADDR_WIDTH-1:0] clr_addr_odd,
  output logic                  clr_we
);

  localparam int CW = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((2 ** ADDR_WIDTH) / 2 - 1);

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CLEAR;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state: advance the sweep, leave CLEAR once the last pair is zeroed.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == CNT_LAST) begin
          state_s = RUN;
          cnt_s   = '0;
        end else begin
          state_s = CLEAR;
          cnt_s   = cnt_r + CW'(1);
        end
      end
      RUN: begin
        state_s = RUN;
        cnt_s   = cnt_r;
      end
      default: begin
        state_s = CLEAR;
        cnt_s   = '0;
      end
    endcase
  end

  assign busy          = (state_r == CLEAR);
  assign clr_we        = busy;
  assign clr_addr_even = ADDR_WIDTH'({cnt_r, 1'b0});
  assign clr_addr_odd  = clr_addr_even | ADDR_WIDTH'(1);

endmodule

// File: rtl/dual_port_ram_param.sv
// True dual-port RAM with byte enables, selectable read-during-write,
// write-write priority with a collision pulse, optional output register and clear sweep.
module dual_port_ram_param
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int RD_MODE        = READ_FIRST,
  parameter int COLLISION_PRIO = PRIO_A,
  parameter int OUT_REG        = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  dual_port_ram_param_if.slave        port_a,
  dual_port_ram_param_if.slave        port_b,
  output logic                        busy,
  output logic                        collision
);

  localparam int NB    = calc_nb(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // The priority port is merged last so its lanes win.
  localparam int FIRST = (COLLISION_PRIO == PRIO_A) ? 1 : 0;
  localparam int LAST  = 1 - FIRST;

  logic [DATA_WIDTH-1:0]            mem_r [DEPTH];
  logic [1:0]                       acc_s, wr_s, vld1_r, vld_s;
  logic [1:0][NB-1:0]               be_s;
  logic [1:0][ADDR_WIDTH-1:0]       addr_s;
  logic [1:0][DATA_WIDTH-1:0]       din_s, old_s, post_s, rdata_s, dout1_r, dout_s;
  logic                             busy_s, clr_we_s;
  logic [ADDR_WIDTH-1:0]            clr_even_s, clr_odd_s;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = base;
    for (int i = 0; i < NB; i++) begin
      res[i*BYTE_WIDTH +: BYTE_WIDTH] = be[i] ? wdata[i*BYTE_WIDTH +: BYTE_WIDTH]
                                              : res[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  dpram_clear_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_ctrl (
    .clk           (clk),
    .reset         (reset),
    .busy          (busy_s),
    .clr_addr_even (clr_even_s),
    .clr_addr_odd  (clr_odd_s),
    .clr_we        (clr_we_s)
  );

  assign acc_s  = {port_b.en, port_a.en} & {2{~busy_s}};
  assign wr_s   = acc_s & {port_b.write_enable, port_a.write_enable};
  assign be_s   = {port_b.byte_enable, port_a.byte_enable};
  assign addr_s = {port_b.address, port_a.address};
  assign din_s  = {port_b.data_in, port_a.data_in};

  // post_s is the word each port's address holds after this edge, both ports' writes applied.
  always_comb begin
    old_s   = '0;
    post_s  = '0;
    rdata_s = '0;
    for (int p = 0; p < 2; p++) begin
      old_s[p]   = mem_r[addr_s[p]];
      post_s[p]  = (wr_s[FIRST] && (addr_s[FIRST] == addr_s[p]))
                   ? merge_lanes(old_s[p], din_s[FIRST], be_s[FIRST]) : old_s[p];
      post_s[p]  = (wr_s[LAST] && (addr_s[LAST] == addr_s[p]))
                   ? merge_lanes(post_s[p], din_s[LAST], be_s[LAST]) : post_s[p];
      rdata_s[p] = (wr_s[p] && (RD_MODE == WRITE_FIRST)) ? post_s[p] : old_s[p];
    end
  end

  // Storage: clear sweep while busy, otherwise user writes of the merged word.
  always_ff @(posedge clk) begin
    if (!reset && clr_we_s) begin
      mem_r[clr_even_s] <= '0;
      mem_r[clr_odd_s]  <= '0;
    end else if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_s[p]) begin
          mem_r[addr_s[p]] <= post_s[p];
        end
      end
    end
  end

  // First output stage and collision pulse; data holds when no access.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld1_r    <= '0;
      dout1_r   <= '0;
      collision <= 1'b0;
    end else begin
      vld1_r <= acc_s;
      for (int p = 0; p < 2; p++) begin
        if (acc_s[p]) begin
          dout1_r[p] <= rdata_s[p];
        end
      end
      collision <= wr_s[0] && wr_s[1] && (addr_s[0] == addr_s[1]);
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [1:0]                 vld2_r;
    logic [1:0][DATA_WIDTH-1:0] dout2_r;

    // Optional second output stage.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld2_r  <= '0;
        dout2_r <= '0;
      end else begin
        vld2_r <= vld1_r;
        for (int p = 0; p < 2; p++) begin
          if (vld1_r[p]) begin
            dout2_r[p] <= dout1_r[p];
          end
        end
      end
    end

    assign vld_s  = vld2_r;
    assign dout_s = dout2_r;
  end else begin : g_no_out_reg
    assign vld_s  = vld1_r;
    assign dout_s = dout1_r;
  end

  assign port_a.data_out = dout_s[0];
  assign port_a.valid    = vld_s[0];
  assign port_b.data_out = dout_s[1];
  assign port_b.valid    = vld_s[1];
  assign busy            = busy_s;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: two instances (c=0: READ_FIRST/PRIO_A/no out reg,
// c=1: WRITE_FIRST/PRIO_B/out reg) share stimulus; a word-level model checks both.
module tb_dual_port_ram_param;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_v [2];
  logic        we_v [2];
  logic [1:0]  be_v [2];
  logic [3:0]  addr_v [2];
  logic [15:0] din_v [2];
  logic [15:0] obs_d [2][2];
  logic        obs_v [2][2];
  logic        obs_busy [2];
  logic        obs_coll [2];
  int          n_pass = 0;
  int          n_total = 0;

  // model state per configuration c and port p
  logic [15:0] mem_m [2][16];
  bit          busy_m [2];
  int          clr_m [2];
  bit          coll_m [2];
  bit          ov_m [2][2];
  logic [15:0] od_m [2][2];
  bit          pv_m [2][2];
  logic [15:0] pd_m [2][2];

  typedef struct {
    logic en_a; logic we_a; logic [1:0] be_a; logic [3:0] addr_a; logic [15:0] din_a;
    logic en_b; logic we_b; logic [1:0] be_b; logic [3:0] addr_b; logic [15:0] din_b;
    logic [15:0] exp0_a; logic [15:0] exp0_b; logic [15:0] exp1_a; logic [15:0] exp1_b;
    logic exp_coll;
  } vec_t;
  vec_t vecs [NV];

  dual_port_ram_param_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW)) ia0 ();
  dual_port_ram_param_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW)) ib0 ();
  dual_port_ram_param_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW)) ia1 ();
  dual_port_ram_param_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW)) ib1 ();

  assign ia0.en = en_v[0]; assign ia0.write_enable = we_v[0]; assign ia0.byte_enable = be_v[0];
  assign ia0.address = addr_v[0]; assign ia0.data_in = din_v[0];
  assign ib0.en = en_v[1]; assign ib0.write_enable = we_v[1]; assign ib0.byte_enable = be_v[1];
  assign ib0.address = addr_v[1]; assign ib0.data_in = din_v[1];
  assign ia1.en = en_v[0]; assign ia1.write_enable = we_v[0]; assign ia1.byte_enable = be_v[0];
  assign ia1.address = addr_v[0]; assign ia1.data_in = din_v[0];
  assign ib1.en = en_v[1]; assign ib1.write_enable = we_v[1]; assign ib1.byte_enable = be_v[1];
  assign ib1.address = addr_v[1]; assign ib1.data_in = din_v[1];

  assign obs_d[0][0] = ia0.data_out; assign obs_v[0][0] = ia0.valid;
  assign obs_d[0][1] = ib0.data_out; assign obs_v[0][1] = ib0.valid;
  assign obs_d[1][0] = ia1.data_out; assign obs_v[1][0] = ia1.valid;
  assign obs_d[1][1] = ib1.data_out; assign obs_v[1][1] = ib1.valid;

  dual_port_ram_param #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
                        .RD_MODE(0), .COLLISION_PRIO(0), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .port_a(ia0), .port_b(ib0),
    .busy(obs_busy[0]), .collision(obs_coll[0]));

  dual_port_ram_param #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
                        .RD_MODE(1), .COLLISION_PRIO(1), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .port_a(ia1), .port_b(ib1),
    .busy(obs_busy[1]), .collision(obs_coll[1]));

  always #5 clk = ~clk;

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference behaviour for one rising edge, using the inputs held across it.
  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int a = 0; a < 16; a++) mem_m[c][a] = 16'h0000;
        busy_m[c] = 1'b1; clr_m[c] = 0; coll_m[c] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          ov_m[c][p] = 1'b0; od_m[c][p] = 16'h0000; pv_m[c][p] = 1'b0; pd_m[c][p] = 16'h0000;
        end
      end else begin
        bit          av [2];
        logic [15:0] ad [2];
        logic [15:0] old [2];
        av[0] = 1'b0; av[1] = 1'b0; ad[0] = 16'h0000; ad[1] = 16'h0000;
        coll_m[c] = 1'b0;
        if (busy_m[c]) begin
          clr_m[c]++;
          if (clr_m[c] == 8) busy_m[c] = 1'b0;
        end else begin
          for (int p = 0; p < 2; p++) old[p] = mem_m[c][addr_v[p]];
          for (int k = 0; k < 2; k++) begin
            int p;
            p = (c == 1) ? k : 1 - k;  // priority port applied last
            if (en_v[p] && we_v[p])
              mem_m[c][addr_v[p]] = (mem_m[c][addr_v[p]] & ~lane_mask(be_v[p])) |
                                    (din_v[p] & lane_mask(be_v[p]));
          end
          for (int p = 0; p < 2; p++) begin
            if (en_v[p]) begin
              av[p] = 1'b1;
              ad[p] = (we_v[p] && c == 1) ? mem_m[c][addr_v[p]] : old[p];
            end
          end
          coll_m[c] = en_v[0] && we_v[0] && en_v[1] && we_v[1] && (addr_v[0] == addr_v[1]);
        end
        for (int p = 0; p < 2; p++) begin
          if (c == 0) begin
            ov_m[c][p] = av[p];
            if (av[p]) od_m[c][p] = ad[p];
          end else begin
            ov_m[c][p] = pv_m[c][p];
            if (pv_m[c][p]) od_m[c][p] = pd_m[c][p];
            pv_m[c][p] = av[p];
            if (av[p]) pd_m[c][p] = ad[p];
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("busy c%0d", c), 32'(obs_busy[c]), 32'(busy_m[c]));
      check($sformatf("collision c%0d", c), 32'(obs_coll[c]), 32'(coll_m[c]));
      for (int p = 0; p < 2; p++) begin
        check($sformatf("valid c%0d p%0d", c, p), 32'(obs_v[c][p]), 32'(ov_m[c][p]));
        check($sformatf("data c%0d p%0d", c, p), 32'(obs_d[c][p]), 32'(od_m[c][p]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input int p, input logic en, input logic we, input logic [1:0] be,
                       input logic [3:0] addr, input logic [15:0] din);
    en_v[p] = en; we_v[p] = we; be_v[p] = be; addr_v[p] = addr; din_v[p] = din;
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
    drive(1, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
  endtask

  task automatic rand_inputs();
    for (int p = 0; p < 2; p++)
      drive(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
            16'($urandom));
  endtask

  // Count edges from reset release until busy drops, with junk on the ports.
  task automatic wait_clear(input string tag);
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int n = 1; n <= 20; n++) begin
      rand_inputs();
      cycle();
      if (!obs_busy[0] && n0 == 0) n0 = n;
      if (!obs_busy[1] && n1 == 0) n1 = n;
      if (n0 != 0 && n1 != 0) break;
    end
    idle();
    check($sformatf("%s busy edges c0", tag), 32'(n0), 32'd8);
    check($sformatf("%s busy edges c1", tag), 32'(n1), 32'd8);
  endtask

  initial begin
    vecs[0]  = '{1'b1,1'b1,2'b11,4'd0,16'h00FF, 1'b1,1'b1,2'b11,4'd1,16'h00AA,
                 16'h0000,16'h0000,16'h00FF,16'h00AA,1'b0};
    vecs[1]  = '{1'b1,1'b0,2'b00,4'd1,16'h0000, 1'b1,1'b0,2'b00,4'd0,16'h0000,
                 16'h00AA,16'h00FF,16'h00AA,16'h00FF,1'b0};
    vecs[2]  = '{1'b1,1'b1,2'b11,4'd7,16'h1234, 1'b0,1'b0,2'b00,4'd0,16'h0000,
                 16'h0000,16'h00FF,16'h1234,16'h00FF,1'b0};
    vecs[3]  = '{1'b1,1'b1,2'b10,4'd7,16'hABCD, 1'b0,1'b0,2'b00,4'd0,16'h0000,
                 16'h1234,16'h00FF,16'hAB34,16'h00FF,1'b0};
    vecs[4]  = '{1'b1,1'b0,2'b00,4'd7,16'h0000, 1'b0,1'b0,2'b00,4'd0,16'h0000,
                 16'hAB34,16'h00FF,16'hAB34,16'h00FF,1'b0};
    vecs[5]  = '{1'b1,1'b1,2'b11,4'd5,16'h1111, 1'b1,1'b1,2'b01,4'd5,16'h2222,
                 16'h0000,16'h0000,16'h1122,16'h1122,1'b1};
    vecs[6]  = '{1'b0,1'b0,2'b00,4'd0,16'h0000, 1'b0,1'b0,2'b00,4'd0,16'h0000,
                 16'h0000,16'h0000,16'h1122,16'h1122,1'b0};
    vecs[7]  = '{1'b1,1'b0,2'b00,4'd5,16'h0000, 1'b1,1'b0,2'b00,4'd5,16'h0000,
                 16'h1111,16'h1111,16'h1122,16'h1122,1'b0};
    vecs[8]  = '{1'b1,1'b1,2'b11,4'd2,16'h0001, 1'b0,1'b0,2'b00,4'd0,16'h0000,
                 16'h0000,16'h1111,16'h0001,16'h1122,1'b0};
    vecs[9]  = '{1'b1,1'b1,2'b11,4'd2,16'h0002, 1'b1,1'b0,2'b00,4'd2,16'h0000,
                 16'h0001,16'h0001,16'h0002,16'h0001,1'b0};
    vecs[10] = '{1'b1,1'b0,2'b00,4'd2,16'h0000, 1'b0,1'b0,2'b00,4'd0,16'h0000,
                 16'h0002,16'h0001,16'h0002,16'h0001,1'b0};

    // reset, clear sweep, then a reset pulse wipes a written word
    idle();
    reset = 1'b1; cycle(); cycle(); reset = 1'b0;
    wait_clear("init");
    drive(0, 1'b1, 1'b1, 2'b11, 4'd3, 16'hBEEF); cycle(); idle();
    reset = 1'b1; cycle(); reset = 1'b0;
    wait_clear("repulse");
    drive(0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0000); cycle(); idle();
    check("clr read c0 valid", 32'(obs_v[0][0]), 32'd1);
    check("clr read c0 data", 32'(obs_d[0][0]), 32'h0000);
    cycle();
    check("clr read c1 valid", 32'(obs_v[1][0]), 32'd1);
    check("clr read c1 data", 32'(obs_d[1][0]), 32'h0000);

    // directed table: c0 checked on the same edge, c1 one edge later
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        drive(0, vecs[i].en_a, vecs[i].we_a, vecs[i].be_a, vecs[i].addr_a, vecs[i].din_a);
        drive(1, vecs[i].en_b, vecs[i].we_b, vecs[i].be_b, vecs[i].addr_b, vecs[i].din_b);
      end else begin
        idle();
      end
      cycle();
      if (i < NV) begin
        check($sformatf("vec%0d c0 A", i), 32'(obs_d[0][0]), 32'(vecs[i].exp0_a));
        check($sformatf("vec%0d c0 B", i), 32'(obs_d[0][1]), 32'(vecs[i].exp0_b));
        check($sformatf("vec%0d c0 coll", i), 32'(obs_coll[0]), 32'(vecs[i].exp_coll));
        check($sformatf("vec%0d c1 coll", i), 32'(obs_coll[1]), 32'(vecs[i].exp_coll));
      end
      if (i > 0) begin
        check($sformatf("vec%0d c1 A", i - 1), 32'(obs_d[1][0]), 32'(vecs[i-1].exp1_a));
        check($sformatf("vec%0d c1 B", i - 1), 32'(obs_d[1][1]), 32'(vecs[i-1].exp1_b));
      end
    end

    // reset at sweep count 3 restarts the full sweep; then latency-2 read on c1
    idle();
    reset = 1'b1; cycle(); reset = 1'b0;
    cycle(); cycle(); cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    wait_clear("midsweep");
    drive(0, 1'b1, 1'b1, 2'b11, 4'd9, 16'h5A5A); cycle(); idle();
    cycle(); cycle();
    drive(0, 1'b1, 1'b0, 2'b00, 4'd9, 16'h0000); cycle(); idle();
    check("lat2 edge1 valid", 32'(obs_v[1][0]), 32'd0);
    cycle();
    check("lat2 edge2 valid", 32'(obs_v[1][0]), 32'd1);
    check("lat2 edge2 data", 32'(obs_d[1][0]), 32'h5A5A);

    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      reset = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
